// File: rtl/fft_pkg.sv
// Shared types and helpers for the 4-point FFT front end.
// Complex words are Q16.16 {re, im}.
package fft_pkg;

    localparam int unsigned FRAC_W = 16;
    localparam int unsigned N_PT   = 4;

    typedef struct packed {
        logic signed [31:0] re;
        logic signed [31:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COOL,
        ST_PEND,
        ST_COOL_PEND
    } issue_state_t;

    function automatic cplx_t to_q16(input logic signed [15:0] sample);
        cplx_t w;
        w.re = {sample, {FRAC_W{1'b0}}};
        w.im = '0;
        return w;
    endfunction

endpackage

// File: rtl/fft4_frame_buffer_if.sv
// Sample-in / frame-out bundle between the audio source, the frame buffer and the FFT stage.
interface fft4_frame_buffer_if #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned CNT_W    = 16
);
    logic                       i_valid;
    logic signed [SAMPLE_W-1:0] i_sample;
    logic                       i_flush;
    logic                       o_ready;
    logic [63:0]                a_o;
    logic [63:0]                b_o;
    logic [63:0]                c_o;
    logic [63:0]                d_o;
    logic                       o_start;
    logic [CNT_W-1:0]           o_frame_cnt;

    modport master (
        output i_valid, i_sample, i_flush,
        input  o_ready, a_o, b_o, c_o, d_o, o_start, o_frame_cnt
    );

    modport slave (
        input  i_valid, i_sample, i_flush,
        output o_ready, a_o, b_o, c_o, d_o, o_start, o_frame_cnt
    );
endinterface

// File: rtl/fft_sample_window.sv
// 4-deep sliding sample window with fill/hop counting.
// win_next and trigger describe the post-shift state of the coming edge.
module fft_sample_window
    import fft_pkg::*;
#(
    parameter int unsigned HOP      = 4,
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       accept,
    input  logic                       flush,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic signed [SAMPLE_W-1:0] win_next [N_PT],
    output logic                       trigger
);

    logic signed [SAMPLE_W-1:0] win [N_PT];
    logic [2:0] fill;
    logic [2:0] fill_next;
    logic [2:0] hop;
    logic [2:0] hop_next;

    always_comb begin
        win_next[0] = win[1];
        win_next[1] = win[2];
        win_next[2] = win[3];
        win_next[3] = sample;
        fill_next   = fill;
        hop_next    = hop;
        trigger     = 1'b0;
        if (accept) begin
            // Hop counting only starts once the first full window has been issued.
            if (fill < 3'(N_PT)) begin
                fill_next = fill + 3'd1;
                trigger   = (fill_next == 3'(N_PT));
            end else if (hop == 3'(HOP - 1)) begin
                hop_next = '0;
                trigger  = 1'b1;
            end else begin
                hop_next = hop + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            win  <= '{default: '0};
            fill <= '0;
            hop  <= '0;
        end else if (accept) begin
            win  <= win_next;
            fill <= fill_next;
            hop  <= hop_next;
        end
    end

endmodule

// File: rtl/fft4_frame_buffer.sv
// Frame issue control for the FFT stage: one-cycle start pulse, a cooldown cycle
// that freezes the outputs, and a single pending slot that backpressures the source.
module fft4_frame_buffer
    import fft_pkg::*;
#(
    parameter int unsigned HOP      = 4,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned CNT_W    = 16
) (
    input logic                clk,
    input logic                rst,
    fft4_frame_buffer_if.slave bus
);

    issue_state_t state;
    issue_state_t state_next;

    logic accept;
    logic trigger;
    logic ready;
    logic issue_now;
    logic issue_snap;
    logic snap_load;

    logic signed [SAMPLE_W-1:0] win_next [N_PT];
    cplx_t win_q [N_PT];
    cplx_t frame [N_PT];
    cplx_t snap  [N_PT];
    logic [CNT_W-1:0] frame_cnt;

    // Ready depends on state only, keeping accept -> trigger -> next-state loop-free.
    assign ready  = (state == ST_IDLE) || (state == ST_COOL);
    assign accept = bus.i_valid & ready & ~bus.i_flush;

    fft_sample_window #(
        .HOP      (HOP),
        .SAMPLE_W (SAMPLE_W)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept),
        .flush    (bus.i_flush),
        .sample   (bus.i_sample),
        .win_next (win_next),
        .trigger  (trigger)
    );

    always_comb begin
        for (int unsigned i = 0; i < N_PT; i++) begin
            win_q[i] = to_q16(16'(win_next[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue_now  = 1'b0;
        issue_snap = 1'b0;
        snap_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trigger) begin
                    issue_now  = 1'b1;
                    state_next = ST_COOL;
                end
            end
            ST_COOL: begin
                snap_load  = trigger;
                state_next = trigger ? ST_PEND : ST_IDLE;
            end
            ST_PEND: begin
                if (bus.i_flush) begin
                    state_next = ST_IDLE;
                end else begin
                    issue_snap = 1'b1;
                    state_next = ST_COOL_PEND;
                end
            end
            ST_COOL_PEND: state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            frame     <= '{default: '0};
            snap      <= '{default: '0};
            frame_cnt <= '0;
        end else begin
            if (snap_load) begin
                snap <= win_q;
            end
            if (issue_now) begin
                frame <= win_q;
            end else if (issue_snap) begin
                frame <= snap;
            end
            if (issue_now || issue_snap) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_start     = (state == ST_COOL) || (state == ST_COOL_PEND);
    assign bus.a_o         = frame[0];
    assign bus.b_o         = frame[1];
    assign bus.c_o         = frame[2];
    assign bus.d_o         = frame[3];
    assign bus.o_frame_cnt = frame_cnt;

endmodule

// File: tb/tb_fft4_frame_buffer.sv
// Directed bench: HOP=4 instance for framing/reset/flush, HOP=1 CNT_W=4 instance for
// backpressure timing and counter wrap.
module tb_fft4_frame_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   k;
    int   nstart;
    logic rb;
    logic [14:1] exp_st  = 14'b00101010101000;
    logic [14:1] exp_rdy = 14'b11110011001111;

    fft4_frame_buffer_if #(.SAMPLE_W(16), .CNT_W(16)) bus4 ();
    fft4_frame_buffer_if #(.SAMPLE_W(16), .CNT_W(4))  bus1 ();

    fft4_frame_buffer #(.HOP(4), .SAMPLE_W(16), .CNT_W(16)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    fft4_frame_buffer #(.HOP(1), .SAMPLE_W(16), .CNT_W(4)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input int s);
        bus4.i_valid  = 1'b1;
        bus4.i_sample = 16'(s);
        tick();
    endtask

    function automatic logic [63:0] q(input int s);
        logic [15:0] t;
        t = s[15:0];
        return {t, 16'h0000, 32'h0000_0000};
    endfunction

    initial begin
        rst           = 1'b0;
        bus4.i_valid  = 1'b0;
        bus4.i_sample = '0;
        bus4.i_flush  = 1'b0;
        bus1.i_valid  = 1'b0;
        bus1.i_sample = '0;
        bus1.i_flush  = 1'b0;
        tick();
        tick();
        chk("rst_a", bus4.a_o, 64'h0);
        chk("rst_d", bus4.d_o, 64'h0);
        chk("rst_cnt", 64'(bus4.o_frame_cnt), 64'd0);
        chk("rst_start", 64'(bus4.o_start), 64'd0);
        chk("rst_ready", 64'(bus4.o_ready), 64'd1);
        chk("rst_ready1", 64'(bus1.o_ready), 64'd1);
        rst = 1'b1;

        // first fill 1..4
        push4(1); chk("f1_s1", 64'(bus4.o_start), 64'd0);
        push4(2); chk("f1_s2", 64'(bus4.o_start), 64'd0);
        push4(3); chk("f1_s3", 64'(bus4.o_start), 64'd0);
        push4(4);
        chk("f1_start", 64'(bus4.o_start), 64'd1);
        chk("f1_a", bus4.a_o, 64'h00010000_00000000);
        chk("f1_b", bus4.b_o, 64'h00020000_00000000);
        chk("f1_c", bus4.c_o, 64'h00030000_00000000);
        chk("f1_d", bus4.d_o, 64'h00040000_00000000);
        chk("f1_cnt", 64'(bus4.o_frame_cnt), 64'd1);
        bus4.i_valid = 1'b0;
        tick();
        chk("f1_pulse", 64'(bus4.o_start), 64'd0);
        chk("f1_hold", bus4.a_o, 64'h00010000_00000000);

        // negative extremes
        push4(-32768);
        chk("f2_hold", bus4.a_o, 64'h00010000_00000000);
        push4(5);
        push4(6);
        push4(-1);
        chk("f2_start", 64'(bus4.o_start), 64'd1);
        chk("f2_a", bus4.a_o, 64'h80000000_00000000);
        chk("f2_b", bus4.b_o, 64'h00050000_00000000);
        chk("f2_c", bus4.c_o, 64'h00060000_00000000);
        chk("f2_d", bus4.d_o, 64'hFFFF0000_00000000);
        chk("f2_cnt", 64'(bus4.o_frame_cnt), 64'd2);

        // reset mid-frame
        push4(1);
        push4(2);
        push4(3);
        bus4.i_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("mr_a", bus4.a_o, 64'h0);
        chk("mr_cnt", 64'(bus4.o_frame_cnt), 64'd0);
        chk("mr_start", 64'(bus4.o_start), 64'd0);
        rst = 1'b1;
        push4(9);  chk("mr_s9", 64'(bus4.o_start), 64'd0);
        push4(10); chk("mr_s10", 64'(bus4.o_start), 64'd0);
        push4(11); chk("mr_s11", 64'(bus4.o_start), 64'd0);
        push4(12);
        chk("mr_start12", 64'(bus4.o_start), 64'd1);
        chk("mr_a9", bus4.a_o, q(9));
        chk("mr_b10", bus4.b_o, q(10));
        chk("mr_c11", bus4.c_o, q(11));
        chk("mr_d12", bus4.d_o, q(12));
        chk("mr_cnt1", 64'(bus4.o_frame_cnt), 64'd1);

        // flush with the 3rd sample
        bus4.i_valid = 1'b0;
        tick();
        push4(20);
        push4(21);
        bus4.i_flush = 1'b1;
        push4(22);
        bus4.i_flush = 1'b0;
        chk("fl_start", 64'(bus4.o_start), 64'd0);
        chk("fl_hold_a", bus4.a_o, q(9));
        chk("fl_hold_d", bus4.d_o, q(12));
        push4(30); chk("fl_s30", 64'(bus4.o_start), 64'd0);
        push4(31); chk("fl_s31", 64'(bus4.o_start), 64'd0);
        push4(32); chk("fl_s32", 64'(bus4.o_start), 64'd0);
        push4(33);
        chk("fl_start33", 64'(bus4.o_start), 64'd1);
        chk("fl_a", bus4.a_o, q(30));
        chk("fl_b", bus4.b_o, q(31));
        chk("fl_c", bus4.c_o, q(32));
        chk("fl_d", bus4.d_o, q(33));
        chk("fl_cnt", 64'(bus4.o_frame_cnt), 64'd2);
        bus4.i_valid = 1'b0;

        // HOP=1 with a holding source
        k = 1;
        nstart = 0;
        for (int c = 1; c <= 14; c++) begin
            bus1.i_valid  = (k <= 8);
            bus1.i_sample = 16'(k);
            rb = bus1.o_ready;
            tick();
            if (rb && k <= 8) k++;
            chk($sformatf("h1_start_c%0d", c), 64'(bus1.o_start), 64'(exp_st[c]));
            chk($sformatf("h1_ready_c%0d", c), 64'(bus1.o_ready), 64'(exp_rdy[c]));
            if (bus1.o_start) begin
                chk($sformatf("h1_a_f%0d", nstart), bus1.a_o, q(nstart + 1));
                chk($sformatf("h1_b_f%0d", nstart), bus1.b_o, q(nstart + 2));
                chk($sformatf("h1_c_f%0d", nstart), bus1.c_o, q(nstart + 3));
                chk($sformatf("h1_d_f%0d", nstart), bus1.d_o, q(nstart + 4));
                nstart++;
            end
        end
        chk("h1_all_taken", 64'(k), 64'd9);
        chk("h1_cnt", 64'(bus1.o_frame_cnt), 64'd5);

        // counter wrap at CNT_W=4
        for (int c = 0; c < 200 && nstart < 17; c++) begin
            rb = bus1.o_ready;
            bus1.i_valid  = 1'b1;
            bus1.i_sample = 16'(k);
            tick();
            if (rb) k++;
            if (bus1.o_start) begin
                nstart++;
                if (nstart == 16) chk("wrap_cnt16", 64'(bus1.o_frame_cnt), 64'd0);
                if (nstart == 17) chk("wrap_cnt17", 64'(bus1.o_frame_cnt), 64'd1);
            end
        end
        bus1.i_valid = 1'b0;
        chk("wrap_reached", 64'(nstart), 64'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft4_frame_buffer.md
Name: fft4_frame_buffer

Overview:
- Upstream feeder for the 4-point FFT stage.
- Collects a stream of 16-bit signed real audio samples into a sliding 4-sample window.
- Converts each window to four 64-bit complex Q16.16 words: {real[31:0], imag[31:0]}, imag = 0.
- Presents the window on a_o..d_o with a one-cycle o_start pulse that drives the FFT stage's i_start; guarantees the FFT stage's two-cycle IDLE/RUN acceptance timing.

Parameters:
- HOP, 4, new samples between successive frames after the first fill; legal 1..4 (4 = no overlap).
- SAMPLE_W, 16, input sample width.
- CNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-low reset, sampled on rising clk.
- i_valid  in  1  i_sample is valid this cycle.
- i_sample  in  SAMPLE_W  signed PCM sample.
- i_flush  in  1  discard window contents and fill count.
- o_ready  out  1  sample accepted when i_valid & o_ready.
- a_o  out  64  window sample 0 (oldest), {real, imag}.
- b_o  out  64  window sample 1.
- c_o  out  64  window sample 2.
- d_o  out  64  window sample 3 (newest).
- o_start  out  1  one-cycle pulse: a_o..d_o hold a new frame.
- o_frame_cnt  out  CNT_W  frames issued, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0 at an edge):
  - a_o..d_o = 0, o_start = 0, o_frame_cnt = 0, o_ready = 1.
  - Window registers, fill count, hop count, pending and cooldown all cleared.
  - Reset mid-frame drops any partial window and any pending start.
- Accept: on i_valid & o_ready, window shifts toward oldest (w0<=w1, w1<=w2, w2<=w3, w3<=sample). i_valid while o_ready=0 is ignored (sample dropped by contract; source must hold).
- Format: real = {sign-extend(sample) to 16 bits, 16'h0000}, i.e. sample<<16 in Q16.16; imag = 32'h0. Output word = {real, imag}. No rounding or saturation.
- Frame trigger:
  - First frame when fill count reaches 4.
  - Thereafter, every HOP accepted samples; hop count resets on each trigger.
  - Trigger is evaluated on the post-shift window, so the frame includes the triggering sample.
- Issue:
  - On trigger, if not in cooldown: at the same edge, load a_o..d_o from the post-shift window, assert o_start for one cycle, increment o_frame_cnt, and enter cooldown for the next cycle.
  - During cooldown, a_o..d_o must not change; the FFT stage reads them in RUN.
- Pending:
  - If a trigger occurs during cooldown, snapshot it into the pending state and deassert o_ready.
  - Issue the snapshot on the first non-cooldown edge.
  - o_ready returns to 1 in the cycle after o_start.
  - Minimum o_start spacing is 2 cycles.
- Hold: a_o..d_o are held until the next issue, so there is no glitch between frames.
- Flush: i_flush=1 clears fill count, hop count and pending; the window is zeroed; a_o..d_o and o_frame_cnt are kept.
  - i_flush has priority over a simultaneous accept; that sample is dropped.
  - A cooldown in progress completes normally.
- Latency: triggering sample accepted at edge N → o_start high and outputs valid in cycle N+1 (registered). Worst case with pending: N+2.
- Counter wrap: o_frame_cnt at 2^CNT_W-1 increments to 0.

Decomposition:
- Shared package fft_pkg:
  - typedef cplx_t as a packed struct {logic signed [31:0] re, im} (64 bits).
  - Q16.16 constant FRAC_W = 16.
  - Point count N_PT = 4.
  - Function to_q16(sample) → cplx_t.
- One natural sub-module: fft_sample_window (4-deep shift register with fill/hop counters and trigger output).
- Top level holds issue/cooldown/pending control and output registers.

Test Plan:
- Reset then 4 samples 1,2,3,4 on consecutive cycles (HOP=4) → one o_start; a_o=64'h00010000_00000000, b_o=64'h00020000_00000000, c_o=64'h00030000_00000000, d_o=64'h00040000_00000000; o_frame_cnt=1.
- Negative sample -1 (16'hFFFF) in position d → d_o=64'hFFFF0000_00000000; a -32768 → 64'h80000000_00000000.
- HOP=1, samples 1..8 with i_valid held high → first start after 4th sample; later triggers fall in cooldown.
  - o_ready drops the cycle after each start; starts spaced exactly 2 cycles.
  - Windows issued are (1..4), (2..5), (3..6)...; no sample lost given the source holds while o_ready=0.
- rst=0 asserted the cycle after the 3rd sample, then samples 9,10,11,12 → first frame is 9,10,11,12; no start occurs during or straight after reset.
- i_flush asserted together with the 3rd sample of a frame → that sample is dropped; outputs keep the previous frame; 4 fresh samples are needed before the next o_start.
- CNT_W=4: issue 17 frames → o_frame_cnt reads 1 after the 17th (wrap via 15→0).
